// File: rtl/s_routing_table_if.sv
// Packet bus between the input FIFO of a router terminal and its routing stage.
// The master drives the incoming packet. The slave returns the packet with its
// next-hop field rewritten.
interface s_routing_table_if #(
  parameter int pckg_sz = 40
);
  logic [pckg_sz-1:0] Data_out_i_in;
  logic [pckg_sz-1:0] Data_out_i;

  modport master (output Data_out_i_in, input  Data_out_i);
  modport slave  (input  Data_out_i_in, output Data_out_i);
endinterface

// File: rtl/s_routing_table.sv
// Routing-decision stage for one input terminal of a mesh router.
// It reads the target row, target column and routing mode of the incoming packet.
// It then replaces the 8-bit next-hop field with the local output terminal:
// 0 = north, 1 = east, 2 = south, 3 = west. An unreachable or self-addressed
// packet gets 8'hFF instead. The result is registered, so latency is one cycle.
module s_routing_table #(
  parameter int id_r    = 0,
  parameter int id_c    = 0,
  parameter int pckg_sz = 40,
  parameter int columns = 4,
  parameter int rows    = 4
) (
  input  logic                clk,
  input  logic                rst,
  s_routing_table_if.slave    bus
);

  // Coordinates are 4-bit fields. The outer limits need a fifth bit, because
  // rows+1 or columns+1 can reach 16 in a full-size mesh.
  localparam logic [3:0] ID_R    = 4'(id_r);
  localparam logic [3:0] ID_C    = 4'(id_c);
  localparam logic [4:0] ROW_MAX = 5'(rows + 1);
  localparam logic [4:0] COL_MAX = 5'(columns + 1);

  logic [3:0]         w_tr;
  logic [3:0]         w_tc;
  logic               w_mode;
  logic [7:0]         w_nxt_jump;
  logic [7:0]         w_unused_jump;
  logic [pckg_sz-1:0] r_data;

  assign w_tr   = bus.Data_out_i_in[pckg_sz-9  -: 4];
  assign w_tc   = bus.Data_out_i_in[pckg_sz-13 -: 4];
  assign w_mode = bus.Data_out_i_in[pckg_sz-17];

  // The incoming next-hop value is overwritten and never read.
  assign w_unused_jump = bus.Data_out_i_in[pckg_sz-1 -: 8];

  // Next-hop decision: first validate the address, then route dimension-ordered.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    w_nxt_jump = 8'hFF;
    if (({1'b0, w_tr} > ROW_MAX) || ({1'b0, w_tc} > COL_MAX) ||
        ((w_tr == ID_R) && (w_tc == ID_C))) begin
      w_nxt_jump = 8'hFF;
    end else if (w_mode) begin
      // Row first: close the row distance, then the column distance.
      if (w_tr < ID_R)       w_nxt_jump = 8'h00;
      else if (w_tr > ID_R)  w_nxt_jump = 8'h02;
      else if (w_tc > ID_C)  w_nxt_jump = 8'h01;
      else                   w_nxt_jump = 8'h03;
    end else begin
      // Column first: close the column distance, then the row distance.
      if (w_tc > ID_C)       w_nxt_jump = 8'h01;
      else if (w_tc < ID_C)  w_nxt_jump = 8'h03;
      else if (w_tr < ID_R)  w_nxt_jump = 8'h00;
      else                   w_nxt_jump = 8'h02;
    end
  end

  // Output register: a synchronous clear discards the word sampled during reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_data <= '0;
    else     r_data <= {w_nxt_jump, bus.Data_out_i_in[pckg_sz-9:0]};
  end

  assign bus.Data_out_i = r_data;

endmodule

// File: tb/tb_s_routing_table.sv
// Directed bench for s_routing_table on router (2,2) of a 4x4 mesh.
// Expected words come from an independent routing model. They are queued when
// a word is driven and popped one cycle later, when the registered output is
// due. Outputs are sampled on the falling edge.
module tb_s_routing_table;

  localparam int PW = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] sb_q[$];
  string         tag_q[$];

  s_routing_table_if #(.pckg_sz(PW)) bus ();

  s_routing_table #(
    .id_r(2), .id_c(2), .pckg_sz(PW), .columns(4), .rows(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference routing for router (2,2). It works from signed hop distances.
  function automatic logic [7:0] route(input int tr, input int tc, input bit mode);
    int dr;
    int dc;
    if (tr > 5 || tc > 5) return 8'hFF;
    dr = tr - 2;
    dc = tc - 2;
    if (dr == 0 && dc == 0) return 8'hFF;
    if (mode && dr != 0)  return (dr < 0) ? 8'h00 : 8'h02;
    if (!mode && dc != 0) return (dc > 0) ? 8'h01 : 8'h03;
    if (dr == 0)          return (dc > 0) ? 8'h01 : 8'h03;
    return (dr < 0) ? 8'h00 : 8'h02;
  endfunction

  // Build a packet. The incoming next-hop byte is junk, so the bench can see it get replaced.
  function automatic logic [PW-1:0] mk(input logic [3:0] tr, input logic [3:0] tc,
                                       input bit mode, input logic [22:0] pay);
    return {8'hA7, tr, tc, mode, pay};
  endfunction

  function automatic logic [PW-1:0] expect_of(input logic [PW-1:0] pkt);
    return {route(int'(pkt[31:28]), int'(pkt[27:24]), pkt[23]), pkt[31:0]};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    logic [PW-1:0] exp;
    string         tg;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      tg  = tag_q.pop_front();
      check(tg, bus.Data_out_i, exp);
    end
  endtask

  // One cycle: check the word due from the last edge, then drive the next one.
  task automatic cycle(input logic r, input logic [PW-1:0] pkt, input string tag);
    @(negedge clk);
    pop_check();
    rst = r;
    bus.Data_out_i_in = pkt;
    sb_q.push_back(r ? '0 : expect_of(pkt));
    tag_q.push_back(tag);
  endtask

  function automatic logic [PW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  initial begin
    bus.Data_out_i_in = '0;

    // Reset with arbitrary input, held for two edges.
    cycle(1'b1, rnd(), "reset_0");
    cycle(1'b1, rnd(), "reset_1");

    // Directed routing cases.
    cycle(1'b0, mk(4'd0, 4'd3, 1'b1, 23'h5A5A5), "row_first_north");
    cycle(1'b0, mk(4'd0, 4'd3, 1'b0, 23'h5A5A5), "col_first_east");
    cycle(1'b0, mk(4'd2, 4'd0, 1'b1, 23'h12345), "same_row_west_m1");
    cycle(1'b0, mk(4'd2, 4'd0, 1'b0, 23'h6789A), "same_row_west_m0");
    cycle(1'b0, mk(4'd5, 4'd2, 1'b1, 23'h7FFFFF), "south_edge_m1");
    cycle(1'b0, mk(4'd5, 4'd2, 1'b0, 23'h000001), "south_edge_m0");
    cycle(1'b0, mk(4'd5, 4'd5, 1'b0, 23'h2AAAAA), "corner_ext_m0");
    cycle(1'b0, mk(4'd1, 4'd1, 1'b1, 23'h155555), "north_west_m1");

    // Invalid addresses.
    cycle(1'b0, mk(4'd6, 4'd1, 1'b1, 23'h0F0F0), "bad_row_6");
    cycle(1'b0, mk(4'd1, 4'd9, 1'b0, 23'h0F0F1), "bad_col_9");
    cycle(1'b0, mk(4'd15, 4'd15, 1'b1, 23'h0F0F2), "bad_row_15");
    cycle(1'b0, mk(4'd2, 4'd2, 1'b1, 23'h0F0F3), "self_m1");
    cycle(1'b0, mk(4'd2, 4'd2, 1'b0, 23'h0F0F4), "self_m0");

    // A held input must give the same registered output on consecutive cycles.
    cycle(1'b0, mk(4'd3, 4'd4, 1'b0, 23'h3C3C3), "stable_a");
    cycle(1'b0, mk(4'd3, 4'd4, 1'b0, 23'h3C3C3), "stable_b");

    // Back-to-back stream with reset asserted on the third word.
    cycle(1'b0, mk(4'd0, 4'd1, 1'b0, 23'h11111), "stream_0");
    cycle(1'b0, mk(4'd4, 4'd2, 1'b1, 23'h22222), "stream_1");
    cycle(1'b1, mk(4'd2, 4'd5, 1'b1, 23'h33333), "stream_2_rst");
    cycle(1'b0, mk(4'd1, 4'd3, 1'b0, 23'h44444), "stream_3");

    // Drain the scoreboard.
    @(negedge clk);
    pop_check();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
